bf_inv_stage: RTL and testbench
===============================

BF_INV_STAGE -- requirements
Module: bf_inv_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed width of each real/imag component.
REQ-002 SHALL have parameter TW_WIDTH, default 16, signed Q1.(TW_WIDTH-1) twiddle component width.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  input triple valid.
REQ-006 in_ready  out  1  stage accepts input this cycle.
REQ-007 in_xa  in  2*DATA_WIDTH  complex A; real in upper half, imag in lower half (fft_inc layout).
REQ-008 in_xb  in  2*DATA_WIDTH  complex B, same packing.
REQ-009 in_w  in  2*TW_WIDTH  forward twiddle W, same packing; block applies conj(W).
REQ-010 in_last  in  1  frame marker, carried with the sample.
REQ-011 out_valid  out  1  output pair valid.
REQ-012 out_ready  in  1  downstream accepts output.
REQ-013 out_ya  out  2*DATA_WIDTH  recovered A.
REQ-014 out_yb  out  2*DATA_WIDTH  recovered B.
REQ-015 out_last  out  1  in_last delayed with its sample.
REQ-016 ovf_sticky  out  1  set on any saturation since last clear.
REQ-017 ovf_clr  in  1  synchronous clear of ovf_sticky.

Function
REQ-018 SHALL compute the inverse radix-2 butterfly: ya = (xa+xb)/2, yb = ((xa-xb)/2)*conj(W), inverting the forward sum/difference butterfly.
REQ-019 Stage 1 SHALL register s = xa+xb and d = xa-xb per component at DATA_WIDTH+1 bits, no truncation.
REQ-020 Stage 2 SHALL register pr = dr*wr + di*wi and pi = di*wr - dr*wi at full width (DATA_WIDTH+TW_WIDTH+2), and s unchanged.
REQ-021 Stage 3 SHALL produce yb components as (p + 2^(TW_WIDTH-1)) >>> TW_WIDTH (round half up), saturated to DATA_WIDTH signed range.
REQ-022 Stage 3 SHALL produce ya components as (s + 1) >>> 1; cannot overflow, no saturation.
REQ-023 Latency SHALL be exactly 3 clk from accepted input to out_valid when out_ready held high; throughput one pair per cycle.
REQ-024 Pipeline SHALL advance as a whole when !(out_valid && !out_ready); in_ready SHALL equal that advance condition combinationally.
REQ-025 Input transfer occurs only when in_valid && in_ready; an invalid slot SHALL propagate as a bubble (valid bit 0) without altering data ordering.
REQ-026 When stalled, out_ya/out_yb/out_last/out_valid SHALL hold stable until out_ready.
REQ-027 ovf_sticky SHALL set on the cycle a saturated yb leaves stage 3 with a valid flag; ovf_clr and a simultaneous saturation SHALL leave ovf_sticky set.
REQ-028 Bubbles SHALL never set ovf_sticky regardless of data contents.

Reset
REQ-029 On rst_n low, all valid flags, out_valid, out_last and ovf_sticky SHALL clear to 0 immediately; out_ya/out_yb reset to 0.
REQ-030 Reset mid-stream SHALL discard all in-flight samples; first post-reset accept appears 3 cycles later.
REQ-031 in_ready SHALL be 1 while out_valid is 0, including during and after reset.

Structure
REQ-032 Component packing macros (CPLX_WIDTH, REAL/IMGN field bounds) SHALL come from shared fft_inc; rounding/saturation constants belong in shared fft package.
REQ-033 One sub-module, cplx_mul_conj (registered conj multiply, stage 2), is natural; everything else inline.

Verification
REQ-034 xa=(100,50), xb=(20,10), W=(32767,0) -> 3 cycles later ya=(60,30), yb=(40,20), ovf_sticky=0.
REQ-035 xa=(32767,32767), xb=(-32768,-32768), W=(23170,-23170) -> ya=(0,0), yb=(0,32767), ovf_sticky=1; ovf_clr pulse -> 0.
REQ-036 Continuous 16 inputs, out_ready held low from cycle 5 for 4 cycles -> no loss or duplication, outputs in order, in_ready low during stall.
REQ-037 in_last on sample 8 of 8 -> out_last high on exactly the 8th output.
REQ-038 rst_n low with 3 samples in flight -> out_valid 0 at once, no stale outputs after release.
REQ-039 Random xa/xb/W (1e5 vectors, random out_ready) vs. rounded reference model -> bit-exact match; forward BF output fed in with W=1 returns (xa,xb) within 1 LSB.

Source files
------------

// File: rtl/bf_inv_stage_pkg.sv
// Shared FFT constants and helpers for the inverse butterfly stage.
// Component packing: real part in the upper half of a word, imaginary part in the lower half.
package bf_inv_stage_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TW_WIDTH   = 16;

    // Packed complex word width for a given component width.
    function automatic int cplx_width(input int comp_width);
        return 2 * comp_width;
    endfunction

    // Full product width of a (w+1)-bit difference times a twiddle, plus one bit for the sum.
    function automatic int prod_width(input int data_width, input int tw_width);
        return data_width + tw_width + 2;
    endfunction

endpackage

// File: rtl/bf_inv_stage_cplx_mul_conj.sv
// Registered complex multiply by the conjugate of b: p = a * conj(b), full precision.
module cplx_mul_conj #(
    parameter int AW = 17,
    parameter int BW = 16,
    parameter int PW = AW + BW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic signed [AW-1:0] ar_i,
    input  logic signed [AW-1:0] ai_i,
    input  logic signed [BW-1:0] br_i,
    input  logic signed [BW-1:0] bi_i,
    output logic signed [PW-1:0] pr_o,
    output logic signed [PW-1:0] pi_o
);

    logic signed [PW-1:0] rr, ii, ir, ri;
    logic signed [PW-1:0] pr_d, pi_d, pr_q, pi_q;

    // Operands are sign-extended to PW first; every partial product fits, so truncation is exact.
    always_comb begin
        rr   = PW'(ar_i) * PW'(br_i);
        ii   = PW'(ai_i) * PW'(bi_i);
        ir   = PW'(ai_i) * PW'(br_i);
        ri   = PW'(ar_i) * PW'(bi_i);
        pr_d = rr + ii;
        pi_d = ir - ri;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q <= '0;
            pi_q <= '0;
        end else if (en_i) begin
            pr_q <= pr_d;
            pi_q <= pi_d;
        end
    end

    assign pr_o = pr_q;
    assign pi_o = pi_q;

endmodule

// File: rtl/bf_inv_stage.sv
// Inverse radix-2 butterfly: ya = (xa+xb)/2, yb = ((xa-xb)/2)*conj(W).
// Three-stage pipeline that advances as a whole whenever the output is not stalled.
module bf_inv_stage
    import bf_inv_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TW_WIDTH   = DEF_TW_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [cplx_width(DATA_WIDTH)-1:0] in_xa,
    input  logic [cplx_width(DATA_WIDTH)-1:0] in_xb,
    input  logic [cplx_width(TW_WIDTH)-1:0]   in_w,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [cplx_width(DATA_WIDTH)-1:0] out_ya,
    output logic [cplx_width(DATA_WIDTH)-1:0] out_yb,
    output logic                            out_last,
    output logic                            ovf_sticky,
    input  logic                            ovf_clr
);

    localparam int DW = DATA_WIDTH;
    localparam int TW = TW_WIDTH;
    localparam int PW = prod_width(DW, TW);
    localparam logic signed [PW-1:0] RND  = {{(PW-TW){1'b0}}, 1'b1, {(TW-1){1'b0}}};
    localparam logic signed [PW-1:0] YMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] YMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW:0]   ONE  = {{DW{1'b0}}, 1'b1};

    logic advance;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    logic signed [DW-1:0] xar, xai, xbr, xbi;
    logic signed [TW-1:0] wr_d, wi_d;
    logic signed [DW:0]   sr_d, si_d, dr_d, di_d;

    assign xar  = $signed(in_xa[2*DW-1:DW]);
    assign xai  = $signed(in_xa[DW-1:0]);
    assign xbr  = $signed(in_xb[2*DW-1:DW]);
    assign xbi  = $signed(in_xb[DW-1:0]);
    assign wr_d = $signed(in_w[2*TW-1:TW]);
    assign wi_d = $signed(in_w[TW-1:0]);
    assign sr_d = (DW+1)'(xar) + (DW+1)'(xbr);
    assign si_d = (DW+1)'(xai) + (DW+1)'(xbi);
    assign dr_d = (DW+1)'(xar) - (DW+1)'(xbr);
    assign di_d = (DW+1)'(xai) - (DW+1)'(xbi);

    logic                 v1_q, last1_q;
    logic signed [DW:0]   sr1_q, si1_q, dr1_q, di1_q;
    logic signed [TW-1:0] wr1_q, wi1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            sr1_q   <= '0;
            si1_q   <= '0;
            dr1_q   <= '0;
            di1_q   <= '0;
            wr1_q   <= '0;
            wi1_q   <= '0;
        end else if (advance) begin
            v1_q    <= in_valid;
            last1_q <= in_last;
            sr1_q   <= sr_d;
            si1_q   <= si_d;
            dr1_q   <= dr_d;
            di1_q   <= di_d;
            wr1_q   <= wr_d;
            wi1_q   <= wi_d;
        end
    end

    logic signed [PW-1:0] pr2, pi2;

    cplx_mul_conj #(
        .AW(DW + 1),
        .BW(TW),
        .PW(PW)
    ) u_mul (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (advance),
        .ar_i (dr1_q),
        .ai_i (di1_q),
        .br_i (wr1_q),
        .bi_i (wi1_q),
        .pr_o (pr2),
        .pi_o (pi2)
    );

    logic               v2_q, last2_q;
    logic signed [DW:0] sr2_q, si2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            sr2_q   <= '0;
            si2_q   <= '0;
        end else if (advance) begin
            v2_q    <= v1_q;
            last2_q <= last1_q;
            sr2_q   <= sr1_q;
            si2_q   <= si1_q;
        end
    end

    logic signed [PW-1:0] qr, qi;
    logic signed [DW:0]   sar, sai;
    logic [DW-1:0]        ybr_d, ybi_d;
    logic                 satr, sati;

    assign qr  = (pr2 + RND) >>> TW;
    assign qi  = (pi2 + RND) >>> TW;
    // s+1 cannot wrap at DW+1 bits, so dropping the LSB is the rounded halving.
    assign sar = sr2_q + ONE;
    assign sai = si2_q + ONE;

    always_comb begin
        satr  = 1'b0;
        sati  = 1'b0;
        ybr_d = qr[DW-1:0];
        ybi_d = qi[DW-1:0];
        if (qr > YMAX) begin
            satr  = 1'b1;
            ybr_d = YMAX[DW-1:0];
        end else if (qr < YMIN) begin
            satr  = 1'b1;
            ybr_d = YMIN[DW-1:0];
        end
        if (qi > YMAX) begin
            sati  = 1'b1;
            ybi_d = YMAX[DW-1:0];
        end else if (qi < YMIN) begin
            sati  = 1'b1;
            ybi_d = YMIN[DW-1:0];
        end
    end

    logic                         out_valid_q, out_last_q, ovf_q;
    logic [cplx_width(DW)-1:0]    ya_q, yb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ya_q        <= '0;
            yb_q        <= '0;
        end else if (advance) begin
            out_valid_q <= v2_q;
            out_last_q  <= last2_q;
            ya_q        <= {sar[DW:1], sai[DW:1]};
            yb_q        <= {ybr_d, ybi_d};
        end
    end

    // A saturation entering the output register wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance && v2_q && (satr || sati)) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_ya     = ya_q;
    assign out_yb     = yb_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_bf_inv_stage.sv
// Directed testbench for bf_inv_stage: known vectors, stall stream, frame marker, reset flush, overflow flag.
module tb_bf_inv_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_xa, in_xb, in_w;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_ya, out_yb;
    logic        ovf_sticky, ovf_clr;

    int assertCount = 0;
    int failCount   = 0;

    int sXar[16], sXai[16], sXbr[16], sXbi[16], sWr[16], sWi[16];

    always #5 clk = ~clk;

    bf_inv_stage #(.DATA_WIDTH(16), .TW_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_xa     (in_xa),
        .in_xb     (in_xb),
        .in_w      (in_w),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ya    (out_ya),
        .out_yb    (out_yb),
        .out_last  (out_last),
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int xar, input int xai, input int xbr, input int xbi,
                                 input int wr, input int wi, input logic valid, input logic last);
        in_xa    = {xar[15:0], xai[15:0]};
        in_xb    = {xbr[15:0], xbi[15:0]};
        in_w     = {wr[15:0], wi[15:0]};
        in_valid = valid;
        in_last  = last;
    endtask

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Reference: returns {ya, yb}, rounding half up with floor shifts on 64-bit integers.
    function automatic logic [63:0] refModel(input int xar, input int xai, input int xbr, input int xbi,
                                             input int wr, input int wi);
        longint sr, si, dr, di, pr, pi, yar, yai;
        sr  = longint'(xar) + xbr;
        si  = longint'(xai) + xbi;
        dr  = longint'(xar) - xbr;
        di  = longint'(xai) - xbi;
        yar = (sr + 1) >>> 1;
        yai = (si + 1) >>> 1;
        pr  = dr * wr + di * wi;
        pi  = di * wr - dr * wi;
        return {yar[15:0], yai[15:0], sat16((pr + 32768) >>> 16), sat16((pi + 32768) >>> 16)};
    endfunction

    task automatic runSingle(input string tag, input int xar, input int xai, input int xbr, input int xbi,
                             input int wr, input int wi, input logic [31:0] expYa, input logic [31:0] expYb,
                             input logic expOvf);
        int lat = 0;
        applyStimulus(xar, xai, xbr, xbi, wr, wi, 1'b1, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            applyStimulus(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        checkOutput({tag, "Lat"}, 64'(lat), 64'd3);
        checkOutput({tag, "Ya"}, 64'(out_ya), 64'(expYa));
        checkOutput({tag, "Yb"}, 64'(out_yb), 64'(expYb));
        checkOutput({tag, "Ovf"}, 64'(ovf_sticky), 64'(expOvf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] expQ[$];
        logic        expLast[$];
        logic [63:0] e;
        logic        eLast;
        logic        sawValid;
        int          sent, got;

        for (int k = 0; k < 16; k++) begin
            sXar[k] = k * 1500 - 9000;
            sXai[k] = 4000 - k * 450;
            sXbr[k] = k * 211 - 1500;
            sXbi[k] = -k * 333;
            sWr[k]  = 32767 - k * 2000;
            sWi[k]  = k * 1900 - 14000;
        end

        rst_n     = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        #12;
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstInReady", 64'(in_ready), 64'd1);
        checkOutput("rstOvf", 64'(ovf_sticky), 64'd0);
        checkOutput("rstYa", 64'(out_ya), 64'd0);
        checkOutput("rstLast", 64'(out_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runSingle("basic", 100, 50, 20, 10, 32767, 0, {16'd60, 16'd30}, {16'd40, 16'd20}, 1'b0);
        runSingle("round", -3, 5, 0, 0, 32767, 0, {16'hFFFF, 16'h0003}, {16'hFFFF, 16'h0002}, 1'b0);
        runSingle("imagW", 1000, 0, 0, 0, 0, 16384, {16'd500, 16'd0}, {16'h0000, 16'hFF06}, 1'b0);
        runSingle("sat", 32767, 32767, -32768, -32768, 23170, -23170, 32'h0, {16'd0, 16'd32767}, 1'b1);

        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        checkOutput("ovfCleared", 64'(ovf_sticky), 64'd0);
        @(posedge clk);
        #1;

        // Clear held high while a saturated sample arrives: the set must win.
        ovf_clr = 1'b1;
        runSingle("satClr", 32767, 32767, -32768, -32768, 23170, -23170, 32'h0, {16'd0, 16'd32767}, 1'b1);
        @(negedge clk);
        checkOutput("ovfClrAfter", 64'(ovf_sticky), 64'd0);
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;

        sawValid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            applyStimulus(32767, 32767, -32768, -32768, 23170, -23170, 1'b0, 1'b0);
            @(negedge clk);
            sawValid = sawValid | ovf_sticky;
            @(posedge clk);
            #1;
        end
        checkOutput("bubbleOvf", 64'(sawValid), 64'd0);

        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 9);
            if (sent < 16)
                applyStimulus(sXar[sent], sXai[sent], sXbr[sent], sXbi[sent], sWr[sent], sWi[sent],
                              1'b1, (sent == 7) || (sent == 15));
            else
                applyStimulus(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
            @(negedge clk);
            if (out_valid && !out_ready)
                checkOutput($sformatf("stallInReady%0d", cyc), 64'(in_ready), 64'd0);
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(sXar[sent], sXai[sent], sXbr[sent], sXbi[sent], sWr[sent], sWi[sent]));
                expLast.push_back((sent == 7) || (sent == 15));
                sent++;
            end
            if (out_valid && out_ready) begin
                checkOutput("streamQueued", 64'(expQ.size() > 0), 64'd1);
                if (expQ.size() > 0) begin
                    e     = expQ.pop_front();
                    eLast = expLast.pop_front();
                    checkOutput($sformatf("stream%0d", got), {out_ya, out_yb}, e);
                    checkOutput($sformatf("streamLast%0d", got), 64'(out_last), 64'(eLast));
                    got++;
                end
            end
            @(posedge clk);
            #1;
        end
        checkOutput("streamCount", 64'(got), 64'd16);
        checkOutput("streamSent", 64'(sent), 64'd16);
        out_ready = 1'b1;

        for (int n = 0; n < 3; n++) begin
            applyStimulus(sXar[n], sXai[n], sXbr[n], sXbi[n], sWr[n], sWi[n], 1'b1, 1'b0);
            @(posedge clk);
            #1;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 64'(out_valid), 64'd0);
        checkOutput("midRstInReady", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            sawValid = sawValid | out_valid;
        end
        checkOutput("postRstStale", 64'(sawValid), 64'd0);
        @(posedge clk);
        #1;
        runSingle("postRst", 100, 50, 20, 10, 32767, 0, {16'd60, 16'd30}, {16'd40, 16'd20}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
